// File: rtl/opl_audio_dac.sv
// rtl/opl_audio_dac.sv - OPL2 sample CDC, DC blocker, ramped gain and 2nd-order sigma-delta DAC
// Purpose: moves the phi2-domain sample into clk, optionally removes DC, applies a
// pop-free volume/mute gain and converts the result to a 1-bit sigma-delta stream.
// Ports:
//   clk              16 MHz DAC clock
//   rst              synchronous reset, active-high
//   sample_tgl       toggles once per new sample (phi2 domain)
//   sample_in[15:0]  signed sample, stable from >= 4 clk before a toggle until the next
//   volume[7:0]      unsigned gain, 128 = unity
//   mute             1 ramps the gain to 0
//   sample_strobe    1-cycle pulse when a sample is captured
//   clip             1-cycle pulse for every cycle the gain stage saturates
//   muted            1 while the effective gain is 0
//   dac_out          sigma-delta bitstream

module opl_audio_dac #(
  parameter int DCB_EN    = 1,
  parameter int DCB_SHIFT = 10,
  parameter int RAMP_DIV  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tgl,
  input  logic [15:0] sample_in,
  input  logic [7:0]  volume,
  input  logic        mute,
  output logic        sample_strobe,
  output logic        clip,
  output logic        muted,
  output logic        dac_out
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
    if (v > 26'sd8388607) return 24'sh7FFFFF;
    else if (v < -26'sd8388608) return 24'sh800000;
    else return v[23:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Toggle-handshake CDC: two sync flops plus a history flop. The sample bus is
  // quasi-static around the toggle, so it is captured directly.
  // ---------------------------------------------------------------------------
  logic [1:0]        r_sync;
  logic              r_prev;
  logic              w_new;
  logic              r_strobe;
  logic signed [15:0] r_x;

  assign w_new = r_sync[1] ^ r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b00;
      r_prev   <= 1'b0;
      r_strobe <= 1'b0;
      r_x      <= 16'sd0;
    end else begin
      r_sync   <= {r_sync[0], sample_tgl};
      r_prev   <= r_sync[1];
      r_strobe <= w_new;
      if (w_new) r_x <= sample_in;
    end
  end

  // ---------------------------------------------------------------------------
  // DC blocker: one-pole high-pass in Q16.8, advanced once per captured sample.
  // ---------------------------------------------------------------------------
  logic signed [15:0] w_dcb;

  generate
    if (DCB_EN != 0) begin : g_dcb
      logic signed [23:0] r_acc;
      logic signed [15:0] r_x_prev;
      logic signed [16:0] w_diff;
      logic signed [23:0] w_leak;
      logic signed [25:0] w_sum;

      assign w_diff = {r_x[15], r_x} - {r_x_prev[15], r_x_prev};
      assign w_leak = r_acc >>> DCB_SHIFT;
      assign w_sum  = {w_diff[16], w_diff, 8'd0}
                    + {{2{r_acc[23]}}, r_acc}
                    - {{2{w_leak[23]}}, w_leak};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc    <= 24'sd0;
          r_x_prev <= 16'sd0;
        end else if (r_strobe) begin
          r_acc    <= sat24(w_sum);
          r_x_prev <= r_x;
        end
      end

      assign w_dcb = r_acc[23:8];
    end else begin : g_bypass
      assign w_dcb = r_x;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Gain ramp: the effective gain only ever moves one LSB per RAMP_DIV cycles,
  // so volume and mute changes never produce a step in the output.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;
  logic [7:0]       w_target;
  logic [7:0]       w_gain_next;
  logic [7:0]       r_eff_gain;
  logic             r_muted;

  assign w_wrap = (r_cnt == CNT_W'(RAMP_DIV - 1));

  always_comb begin
    w_target    = mute ? 8'd0 : volume;
    w_gain_next = r_eff_gain;
    if (w_wrap) begin
      if (r_eff_gain < w_target)      w_gain_next = r_eff_gain + 8'd1;
      else if (r_eff_gain > w_target) w_gain_next = r_eff_gain - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_eff_gain <= 8'd0;
      r_muted    <= 1'b1;
    end else begin
      r_cnt      <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_eff_gain <= w_gain_next;
      // Derived from the next gain so muted changes on the same edge as the gain.
      r_muted    <= (w_gain_next == 8'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Gain stage: dcb x gain / 128 with 16-bit saturation.
  // ---------------------------------------------------------------------------
  logic signed [24:0] w_prod;
  logic signed [24:0] w_shift;
  logic signed [15:0] r_scaled;
  logic               r_clip;

  assign w_prod  = $signed({{9{w_dcb[15]}}, w_dcb}) * $signed({17'd0, r_eff_gain});
  assign w_shift = w_prod >>> 7;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scaled <= 16'sd0;
      r_clip   <= 1'b0;
    end else if (w_shift > 25'sd32767) begin
      r_scaled <= 16'sh7FFF;
      r_clip   <= 1'b1;
    end else if (w_shift < -25'sd32768) begin
      r_scaled <= 16'sh8000;
      r_clip   <= 1'b1;
    end else begin
      r_scaled <= w_shift[15:0];
      r_clip   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Second-order sigma-delta with saturating integrators. Both integrators see
  // the same feedback; the second one integrates the previous first-stage value.
  // ---------------------------------------------------------------------------
  logic signed [16:0] w_fb;
  logic signed [25:0] w_i1_sum;
  logic signed [25:0] w_i2_sum;
  logic signed [23:0] w_i1_next;
  logic signed [23:0] w_i2_next;
  logic signed [23:0] r_i1;
  logic signed [23:0] r_i2;
  logic               r_dac;

  assign w_fb      = r_dac ? 17'sd32767 : -17'sd32768;
  assign w_i1_sum  = {{2{r_i1[23]}}, r_i1} + {{10{r_scaled[15]}}, r_scaled} - {{9{w_fb[16]}}, w_fb};
  assign w_i2_sum  = {{2{r_i2[23]}}, r_i2} + {{2{r_i1[23]}}, r_i1} - {{9{w_fb[16]}}, w_fb};
  assign w_i1_next = sat24(w_i1_sum);
  assign w_i2_next = sat24(w_i2_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1  <= 24'sd0;
      r_i2  <= 24'sd0;
      r_dac <= 1'b0;
    end else begin
      r_i1  <= w_i1_next;
      r_i2  <= w_i2_next;
      r_dac <= ~w_i2_next[23];
    end
  end

  assign sample_strobe = r_strobe;
  assign clip          = r_clip;
  assign muted         = r_muted;
  assign dac_out       = r_dac;

endmodule

// File: tb/tb_opl_audio_dac.sv
// tb/tb_opl_audio_dac.sv - self-checking bench for opl_audio_dac (bypass and DC-blocker builds)

module tb_opl_audio_dac;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tgl;
  logic [15:0] sample_in;
  logic [7:0]  volume;
  logic        mute;
  logic        s0_strobe, s0_clip, s0_muted, s0_dac;
  logic        s1_strobe, s1_clip, s1_muted, s1_dac;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opl_audio_dac #(.DCB_EN(0), .DCB_SHIFT(10), .RAMP_DIV(16)) dut0 (
    .clk(clk), .rst(rst), .sample_tgl(sample_tgl), .sample_in(sample_in),
    .volume(volume), .mute(mute), .sample_strobe(s0_strobe), .clip(s0_clip),
    .muted(s0_muted), .dac_out(s0_dac)
  );

  opl_audio_dac #(.DCB_EN(1), .DCB_SHIFT(10), .RAMP_DIV(16)) dut1 (
    .clk(clk), .rst(rst), .sample_tgl(sample_tgl), .sample_in(sample_in),
    .volume(volume), .mute(mute), .sample_strobe(s1_strobe), .clip(s1_clip),
    .muted(s1_muted), .dac_out(s1_dac)
  );

  // Ramp reference: every 16th cycle after reset the gain moves one step toward target.
  int m_cyc;
  int m_gain;
  int m_tgt;
  assign m_tgt = mute ? 0 : int'(volume);

  always @(posedge clk) begin
    if (rst) begin
      m_cyc  <= 0;
      m_gain <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc + 1) % 16 == 0)
        m_gain <= (m_gain < m_tgt) ? m_gain + 1 : (m_gain > m_tgt) ? m_gain - 1 : m_gain;
    end
  end

  typedef struct {
    int x;
    int vol;
    int exp_scaled;
    int exp_clip;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void gain_model(input int x, input int g, output int y, output int c);
    real    r;
    longint q;
    r = $floor(real'(x) * real'(g) / 128.0);
    q = longint'(r);
    c = 0;
    if (q > 32767) begin q = 32767; c = 1; end
    else if (q < -32768) begin q = -32768; c = 1; end
    y = int'(q);
  endfunction

  task automatic send_sample(input int x, output int lat);
    sample_in  = 16'(x);
    tick(4);
    sample_tgl = ~sample_tgl;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!s0_strobe && lat < 8);
  endtask

  task automatic apply_gain(input string name, input int x, input int exp_s, input int exp_c);
    int lat;
    send_sample(x, lat);
    check({name, "_latency"}, lat, 3);
    tick(1);
    check({name, "_scaled"}, $signed(dut0.r_scaled), exp_s);
    check({name, "_clip"}, s0_clip, exp_c);
  endtask

  task automatic density(input string name, input int scaled_exp);
    int  ones;
    real e;
    ones = 0;
    e = real'(scaled_exp + 32768) * 4096.0 / 65535.0;
    repeat (4096) begin
      tick(1);
      ones += int'(s0_dac);
    end
    check_range(name, ones, longint'($ceil(e - 40.96)), longint'($floor(e + 40.96)));
  endtask

  task automatic ramp_track(input int n, output int decreases);
    int prev;
    prev = int'(dut0.r_eff_gain);
    decreases = 0;
    repeat (n) begin
      tick(1);
      check("eff_gain_track", dut0.r_eff_gain, m_gain);
      check("muted_track", s0_muted, (m_gain == 0));
      if (int'(dut0.r_eff_gain) < prev) decreases++;
      prev = int'(dut0.r_eff_gain);
    end
  endtask

  initial begin
    vec_t   vecs[$];
    int     c, lat, n_str, dec, y, cl, x, got, prev, incr, tmo, w;
    longint acc_m, xp;

    vecs.push_back('{4660,    128, 4660,   0});
    vecs.push_back('{-1,      128, -1,     0});
    vecs.push_back('{32767,   128, 32767,  0});
    vecs.push_back('{-32768,  128, -32768, 0});
    vecs.push_back('{100,     255, 199,    0});
    vecs.push_back('{-100,    255, -200,   0});
    vecs.push_back('{16448,   255, 32767,  0});
    vecs.push_back('{16449,   255, 32767,  1});
    vecs.push_back('{-16448,  255, -32768, 0});
    vecs.push_back('{-16449,  255, -32768, 1});

    rst = 1'b1; sample_tgl = 1'b0; sample_in = 16'd0; volume = 8'd128; mute = 1'b0;
    tick(4);
    check("rst_dac", s0_dac, 0);
    check("rst_strobe", s0_strobe, 0);
    check("rst_clip", s0_clip, 0);
    check("rst_muted", s0_muted, 1);
    check("rst_gain", dut0.r_eff_gain, 0);
    check("rst_scaled", $signed(dut0.r_scaled), 0);
    check("rst_dcb", $signed(dut1.w_dcb), 0);
    rst = 1'b0;

    // Ramp up to unity
    c = 0;
    while (s0_muted && c < 40) begin
      tick(1);
      c++;
    end
    check("first_ramp_step", c, 16);
    check("gain_after_first_step", dut0.r_eff_gain, 1);
    tick(2047 - c);
    check("gain_at_2047", dut0.r_eff_gain, 127);
    tick(1);
    check("gain_at_2048", dut0.r_eff_gain, 128);
    tick(200);
    check("gain_holds", dut0.r_eff_gain, 128);

    // CDC latency and capture
    sample_in = 16'h1234;
    tick(4);
    sample_tgl = ~sample_tgl;
    tick(1); check("cdc_edge1", s0_strobe, 0);
    tick(1); check("cdc_edge2", s0_strobe, 0);
    tick(1); check("cdc_edge3", s0_strobe, 1);
    check("cdc_edge3_dcb_build", s1_strobe, 1);
    check("cdc_x", dut0.r_x, 16'h1234);
    tick(1); check("cdc_edge4", s0_strobe, 0);
    n_str = 1;
    for (int k = 4; k < 100; k++) begin
      if (k == 50) sample_in = 16'h5678;
      tick(1);
      n_str += int'(s0_strobe);
    end
    sample_tgl = ~sample_tgl;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (s0_strobe) begin
        n_str++;
        if (lat == 0) lat = k;
      end
    end
    check("cdc_two_strobes", n_str, 2);
    check("cdc_second_latency", lat, 3);
    check("cdc_second_x", dut0.r_x, 16'h5678);

    // Ones density at unity gain
    apply_gain("dens0", 0, 0, 0);
    tick(200);
    density("density_zero", 0);
    apply_gain("dens_pos", 16384, 16384, 0);
    tick(200);
    density("density_pos_half", 16384);
    apply_gain("dens_neg", -16384, -16384, 0);
    tick(200);
    density("density_neg_half", -16384);

    // Random samples at unity gain
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      gain_model(x, 128, y, cl);
      apply_gain("rand128", x, y, cl);
    end

    // Table vectors (volume change waits for the ramp to settle)
    foreach (vecs[i]) begin
      if (vecs[i].vol != int'(volume)) begin
        volume = 8'(vecs[i].vol);
        tick(256 * 16 + 16);
        check("vol_settled", dut0.r_eff_gain, vecs[i].vol);
      end
      apply_gain("vec", vecs[i].x, vecs[i].exp_scaled, vecs[i].exp_clip);
    end

    // Sustained saturation: clip every cycle
    apply_gain("sat_pos", 30000, 32767, 1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("sat_pos_clip_hold", s0_clip, 1);
      check("sat_pos_scaled_hold", $signed(dut0.r_scaled), 32767);
    end
    apply_gain("sat_neg", -30000, -32768, 1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("sat_neg_clip_hold", s0_clip, 1);
      check("sat_neg_scaled_hold", $signed(dut0.r_scaled), -32768);
    end

    // Random samples at maximum gain
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(65535)) - 32768;
      gain_model(x, 255, y, cl);
      apply_gain("rand255", x, y, cl);
    end

    // Mute ramp and mid-ramp reversal
    volume = 8'd128;
    tick(256 * 16 + 16);
    apply_gain("mute_prep", 0, 0, 0);
    mute = 1'b1;
    ramp_track(2100, dec);
    check("mute_gain_zero", dut0.r_eff_gain, 0);
    check("mute_muted", s0_muted, 1);
    density("density_muted", 0);
    mute = 1'b0;
    ramp_track(2100, dec);
    check("unmute_gain", dut0.r_eff_gain, 128);
    mute = 1'b1;
    ramp_track(1024, dec);
    check_range("mid_ramp_gain", dut0.r_eff_gain, 63, 65);
    mute = 1'b0;
    ramp_track(1100, dec);
    check("reverse_no_decrease", dec, 0);
    check("reverse_final_gain", dut0.r_eff_gain, 128);

    // Reset mid-operation, then DC blocker step response
    sample_in = 16'd0;
    rst = 1'b1;
    tick(2);
    check("midrst_gain", dut0.r_eff_gain, 0);
    check("midrst_muted", s1_muted, 1);
    check("midrst_dac", s1_dac, 0);
    check("midrst_dcb", $signed(dut1.w_dcb), 0);
    rst = 1'b0;
    acc_m = 0; xp = 0; incr = 0; tmo = 0; prev = 0; got = 0;
    sample_in = 16'd10000;
    tick(4);
    for (int i = 0; i < 8192; i++) begin
      sample_tgl = ~sample_tgl;
      w = 0;
      do begin
        tick(1);
        w++;
      end while (!s1_strobe && w < 8);
      if (!s1_strobe) tmo++;
      tick(1);
      acc_m = acc_m + (10000 - xp) * 256 - (acc_m >>> 10);
      if (acc_m > 8388607) acc_m = 8388607;
      if (acc_m < -8388608) acc_m = -8388608;
      xp = 10000;
      got = int'($signed(dut1.w_dcb));
      check("dcb_model", got, acc_m >>> 8);
      if (i == 0) check("dcb_peak", got, 10000);
      else if (got > prev) incr++;
      prev = got;
    end
    check("dcb_strobe_timeouts", tmo, 0);
    check("dcb_monotonic", incr, 0);
    check_range("dcb_final", got, -9, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
